// File: rtl/veridog_pkg.sv
// Shared definitions for the veridog screen layers: screen geometry,
// blitter state encoding and default colour keys.
package veridog_pkg;

  localparam int unsigned SCREEN_W     = 160;
  localparam int unsigned SCREEN_H     = 120;
  localparam int unsigned COLOUR_WIDTH = 9;

  typedef enum logic [1:0] {
    BLIT_IDLE  = 2'd0,
    BLIT_FETCH = 2'd1,
    BLIT_FLUSH = 2'd2,
    BLIT_DONE  = 2'd3
  } blit_state_e;

  // Colour keys commonly used as the transparent colour in sprite art.
  localparam logic [COLOUR_WIDTH-1:0] KEY_BLACK   = 9'h000;
  localparam logic [COLOUR_WIDTH-1:0] KEY_MAGENTA = 9'h1C7;

  // Drain count held in FLUSH: ROM read of the last pixel plus the output stage.
  localparam logic [1:0] FLUSH_LAST = 2'd2;

  // Counter width able to hold 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_blit_raster_counter.sv
// Column/row raster counter: row-major sweep with wrap and a last-pixel flag.
module raster_counter
  import veridog_pkg::*;
#(
  parameter int unsigned COLS = 160,
  parameter int unsigned ROWS = 120,
  parameter int unsigned CW   = cnt_width(COLS),
  parameter int unsigned RW   = cnt_width(ROWS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          advance,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last_c
);

  logic col_end_c;

  // Wrap and last-pixel decode from the current count.
  always_comb begin
    col_end_c = (col == CW'(COLS - 1));
    last_c    = col_end_c && (row == RW'(ROWS - 1));
  end

  // Count position: clear restarts at (0,0), advance steps one pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      if (col_end_c) begin
        col <= '0;
        row <= row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sprite_blit.sv
// Sprite raster engine: sweeps a SPRITE_W x SPRITE_H rectangle, reads each
// colour from an external sync-read ROM and drives plot strobes to the VGA
// adapter. Optional feature macro: TRANSPARENCY_EN (colour-keyed pixels are
// skipped).
module sprite_blit
  import veridog_pkg::*;
#(
  parameter int unsigned X_WIDTH      = 8,
  parameter int unsigned Y_WIDTH      = 7,
  parameter int unsigned COLOUR_WIDTH = veridog_pkg::COLOUR_WIDTH,
  parameter int unsigned SPRITE_W     = 160,
  parameter int unsigned SPRITE_H     = 120,
  parameter int unsigned ADDR_WIDTH   = 15,
  parameter logic [COLOUR_WIDTH-1:0] TRANS_COLOUR = COLOUR_WIDTH'(KEY_BLACK)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  input  logic [X_WIDTH-1:0]      xInit,
  input  logic [Y_WIDTH-1:0]      yInit,
  output logic [ADDR_WIDTH-1:0]   romAddr,
  input  logic [COLOUR_WIDTH-1:0] romData,
  output logic [X_WIDTH-1:0]      xOut,
  output logic [Y_WIDTH-1:0]      yOut,
  output logic [COLOUR_WIDTH-1:0] colour,
  output logic                    writeEn,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned CW   = cnt_width(SPRITE_W);
  localparam int unsigned RW   = cnt_width(SPRITE_H);
  localparam int unsigned XS_W = X_WIDTH + 1;
  localparam int unsigned YS_W = Y_WIDTH + 1;

`ifdef TRANSPARENCY_EN
  localparam bit TRANS_EN = 1'b1;
`else
  localparam bit TRANS_EN = 1'b0;
`endif

  blit_state_e        state;
  logic [X_WIDTH-1:0] x0;
  logic [Y_WIDTH-1:0] y0;
  logic [1:0]         flush_cnt;
  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic               last_c;
  logic               clear_c;
  logic               advance_c;
  logic               s1_valid;
  logic [XS_W-1:0]    s1_x;
  logic [YS_W-1:0]    s1_y;
  logic               keyed_c;
  logic               on_screen_c;

  // Counter control: restart on accepted start, step while fetching.
  always_comb begin
    clear_c     = (state == BLIT_IDLE) && start;
    advance_c   = (state == BLIT_FETCH) && !last_c;
    keyed_c     = TRANS_EN && (romData == TRANS_COLOUR);
    on_screen_c = (s1_x < XS_W'(SCREEN_W)) && (s1_y < YS_W'(SCREEN_H));
  end

  raster_counter #(
    .COLS (SPRITE_W),
    .ROWS (SPRITE_H),
    .CW   (CW),
    .RW   (RW)
  ) u_raster (
    .clk     (clk),
    .rst_n   (resetn),
    .clear   (clear_c),
    .advance (advance_c),
    .col     (col),
    .row     (row),
    .last_c  (last_c)
  );

  // Sweep sequencer: origin latch, ROM address, busy and done.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= BLIT_IDLE;
      x0        <= '0;
      y0        <= '0;
      romAddr   <= '0;
      flush_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        BLIT_IDLE: begin
          if (start) begin
            x0      <= xInit;
            y0      <= yInit;
            romAddr <= '0;
            busy    <= 1'b1;
            state   <= BLIT_FETCH;
          end
        end
        BLIT_FETCH: begin
          if (last_c) begin
            flush_cnt <= '0;
            state     <= BLIT_FLUSH;
          end else begin
            romAddr <= romAddr + ADDR_WIDTH'(1);
          end
        end
        BLIT_FLUSH: begin
          if (flush_cnt == FLUSH_LAST) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= BLIT_DONE;
          end else begin
            flush_cnt <= flush_cnt + 2'd1;
          end
        end
        BLIT_DONE: begin
          state <= BLIT_IDLE;
        end
        default: begin
          state <= BLIT_IDLE;
        end
      endcase
    end
  end

  // Pixel pipeline: coordinates wait one cycle for the ROM, then plot.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      xOut     <= '0;
      yOut     <= '0;
      colour   <= '0;
      writeEn  <= 1'b0;
    end else begin
      s1_valid <= (state == BLIT_FETCH);
      s1_x     <= XS_W'(x0) + XS_W'(col);
      s1_y     <= YS_W'(y0) + YS_W'(row);
      xOut     <= s1_x[X_WIDTH-1:0];
      yOut     <= s1_y[Y_WIDTH-1:0];
      colour   <= romData;
      writeEn  <= s1_valid && on_screen_c && !keyed_c;
    end
  end

endmodule

// File: tb/tb_sprite_blit.sv
// Directed bench for sprite_blit: a 4x2 instance and a 1x1 instance, each
// fed by a ROM whose data equals its address.
module tb_sprite_blit;

`ifdef TRANSPARENCY_EN
  localparam bit TRANS = 1'b1;
`else
  localparam bit TRANS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn;
  logic       start0, start1;
  logic [7:0] x_init;
  logic [6:0] y_init;

  logic [14:0] addr0, addr1;
  logic [8:0]  rom0, rom1;
  logic [7:0]  x0o, x1o;
  logic [6:0]  y0o, y1o;
  logic [8:0]  c0, c1;
  logic        we0, we1, busy0, busy1, done0, done1;

  always #5 clk = ~clk;

  // Sync-read ROM models: data = address, one cycle late.
  always @(posedge clk) begin
    rom0 <= addr0[8:0];
    rom1 <= addr1[8:0];
  end

  sprite_blit #(.SPRITE_W(4), .SPRITE_H(2)) dut0 (
    .clk(clk), .resetn(resetn), .start(start0), .xInit(x_init), .yInit(y_init),
    .romAddr(addr0), .romData(rom0), .xOut(x0o), .yOut(y0o), .colour(c0),
    .writeEn(we0), .busy(busy0), .done(done0)
  );

  sprite_blit #(.SPRITE_W(1), .SPRITE_H(1)) dut1 (
    .clk(clk), .resetn(resetn), .start(start1), .xInit(x_init), .yInit(y_init),
    .romAddr(addr1), .romData(rom1), .xOut(x1o), .yOut(y1o), .colour(c1),
    .writeEn(we1), .busy(busy1), .done(done1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int px[16], py[16], pc[16], pk[16];
  int nplot, ndone, done_k, busy_k1, busy_end, addr_k0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One sweep: start at edge 0, then observe ncyc edges; optional extra start pulses.
  task automatic sweep(input bit sel, input int xi, input int yi, input int ncyc,
                       input int pulse_a, input int pulse_b);
    @(negedge clk);
    x_init = 8'(xi);
    y_init = 7'(yi);
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    addr_k0 = sel ? int'(addr1) : int'(addr0);
    x_init = ~x_init;
    y_init = ~y_init;
    nplot = 0; ndone = 0; done_k = -1; busy_k1 = -1;
    for (int k = 1; k <= ncyc; k++) begin
      if (k == pulse_a || k == pulse_b) begin
        if (sel) start1 = 1'b1; else start0 = 1'b1;
      end
      @(posedge clk);
      #1;
      start0 = 1'b0;
      start1 = 1'b0;
      if (sel ? we1 : we0) begin
        if (nplot < 16) begin
          px[nplot] = sel ? int'(x1o) : int'(x0o);
          py[nplot] = sel ? int'(y1o) : int'(y0o);
          pc[nplot] = sel ? int'(c1) : int'(c0);
          pk[nplot] = k;
        end
        nplot++;
      end
      if (sel ? done1 : done0) begin
        ndone++;
        done_k = k;
      end
      if (k == 1) busy_k1 = sel ? int'(busy1) : int'(busy0);
    end
    busy_end = sel ? int'(busy1) : int'(busy0);
  endtask

  // Expected plot list for origin (xo,yo) and a w x h sprite with ROM=addr.
  task automatic check_sweep(input string tag, input int xo, input int yo,
                             input int w, input int h);
    int en = 0;
    for (int a = 0; a < w * h; a++) begin
      int ex = xo + a % w;
      int ey = yo + a / w;
      bit vis = (ex < 160) && (ey < 120) && !(TRANS && a == 0);
      if (vis) begin
        if (en < nplot && en < 16) begin
          chk({tag, "_x"},   px[en], ex % 256);
          chk({tag, "_y"},   py[en], ey % 128);
          chk({tag, "_col"}, pc[en], a);
          chk({tag, "_cyc"}, pk[en], 2 + a);
        end
        en++;
      end
    end
    chk({tag, "_nplot"},   nplot, en);
    chk({tag, "_ndone"},   ndone, 1);
    chk({tag, "_done_at"}, done_k, w * h + 3);
    chk({tag, "_busy1"},   busy_k1, 1);
    chk({tag, "_busyend"}, busy_end, 0);
  endtask

  initial begin
    resetn = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    x_init = '0;
    y_init = '0;
    #3 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we",   int'(we0),   0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_addr", int'(addr0), 0);
    chk("rst_x",    int'(x0o),   0);
    @(negedge clk);
    resetn = 1'b1;

    // Basic 4x2 sweep at (10,20).
    sweep(1'b0, 10, 20, 14, -1, -1);
    check_sweep("s1", 10, 20, 4, 2);
    chk("s1_addr0", addr_k0, 0);

    // Bottom-right corner: only in-bounds pixels plotted.
    sweep(1'b0, 158, 119, 14, -1, -1);
    check_sweep("s2", 158, 119, 4, 2);

    // Start pulses mid-sweep and during DONE are ignored.
    sweep(1'b0, 10, 20, 14, 5, 12);
    check_sweep("s3", 10, 20, 4, 2);

    // Async reset after the third plot, then a fresh sweep from (0,0).
    @(negedge clk);
    x_init = 8'd5;
    y_init = 7'd6;
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    repeat (4) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("s4_we",   int'(we0),   0);
    chk("s4_busy", int'(busy0), 0);
    chk("s4_x",    int'(x0o),   0);
    chk("s4_y",    int'(y0o),   0);
    chk("s4_col",  int'(c0),    0);
    chk("s4_addr", int'(addr0), 0);
    @(negedge clk);
    resetn = 1'b1;
    sweep(1'b0, 0, 0, 14, -1, -1);
    check_sweep("s4r", 0, 0, 4, 2);
    chk("s4r_addr0", addr_k0, 0);

    // Single-pixel sprite.
    sweep(1'b1, 37, 45, 8, -1, -1);
    check_sweep("s6", 37, 45, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
